// File: rtl/register_file_mp.sv
// Two-read / one-write register file with registered reads, write-to-read bypass
// and a one-entry-per-cycle clear sweep instead of a parallel array reset.
`default_nettype none

module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1,
  output logic [DATA_WIDTH-1:0] rs2,
  output logic                  rs_valid,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data
);

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  wr_ok_p0;
  logic [DATA_WIDTH-1:0] rd1_stored_p0;
  logic [DATA_WIDTH-1:0] rd2_stored_p0;
  logic [DATA_WIDTH-1:0] rd1_p0;
  logic [DATA_WIDTH-1:0] rd2_p0;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  // Implemented, writable and not the hard-wired zero entry.
  function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] a);
    return addr_in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  wr_ok,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data
  );
    if (!addr_live(a)) begin
      return '0;
    end
    if (wr_ok && (wr_addr == a)) begin
      return wr_data;
    end
    return stored;
  endfunction

  // ---- stage p0: request decode, array lookup and bypass select ----
  assign wr_ok_p0 = !rst && (state == READY) && !clear_req &&
                    write_enable && addr_live(write_addr);

  always_comb begin
    rd1_stored_p0 = '0;
    rd2_stored_p0 = '0;
    if (addr_in_range(rs1_addr)) begin
      rd1_stored_p0 = regs[rs1_addr];
    end
    if (addr_in_range(rs2_addr)) begin
      rd2_stored_p0 = regs[rs2_addr];
    end
  end

  assign rd1_p0 = read_sel(rs1_addr, rd1_stored_p0, wr_ok_p0, write_addr, write_data);
  assign rd2_p0 = read_sel(rs2_addr, rd2_stored_p0, wr_ok_p0, write_addr, write_data);

  // Array storage has no reset so it can map onto distributed RAM; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) begin
      regs[clr_idx] <= '0;
    end else if (wr_ok_p0) begin
      regs[write_addr] <= write_data;
    end
  end

  // ---- stage p1: control FSM and registered read outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      ready    <= 1'b0;
      rs1      <= '0;
      rs2      <= '0;
      rs_valid <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rs_valid <= 1'b0;
          rs1      <= '0;
          rs2      <= '0;
          clr_idx  <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          rs_valid <= read_enable;
          if (read_enable) begin
            rs1 <= rd1_p0;
            rs2 <= rd2_p0;
          end
          if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default instance (32 regs, zero reg) and a
// 24-entry instance without zero reg, both tracked by an array-level model.
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i [2];
  logic        clr_i [2];
  logic        re_i  [2];
  logic        we_i  [2];
  logic [4:0]  a1_i  [2];
  logic [4:0]  a2_i  [2];
  logic [4:0]  wa_i  [2];
  logic [31:0] wd_i  [2];

  logic        rdy_a, vld_a, rdy_b, vld_b;
  logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;

  register_file_mp dut_a (
    .clk(clk), .rst(rst_i[0]), .clear_req(clr_i[0]), .ready(rdy_a),
    .read_enable(re_i[0]), .rs1_addr(a1_i[0]), .rs2_addr(a2_i[0]),
    .rs1(rs1_a), .rs2(rs2_a), .rs_valid(vld_a),
    .write_enable(we_i[0]), .write_addr(wa_i[0]), .write_data(wd_i[0])
  );

  register_file_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(24), .ZERO_REG(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_i[1]), .clear_req(clr_i[1]), .ready(rdy_b),
    .read_enable(re_i[1]), .rs1_addr(a1_i[1]), .rs2_addr(a2_i[1]),
    .rs1(rs1_b), .rs2(rs2_b), .rs_valid(vld_b),
    .write_enable(we_i[1]), .write_addr(wa_i[1]), .write_data(wd_i[1])
  );

  // Reference model state
  logic [31:0] m_regs [2][32];
  int          busy   [2];
  logic        m_rdy  [2];
  logic        m_vld  [2];
  logic        known  [2];
  logic [31:0] m_rs1  [2];
  logic [31:0] m_rs2  [2];

  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  function automatic int nr(int k);
    return (k == 0) ? 32 : 24;
  endfunction

  function automatic bit zr(int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] rdval(int k, logic [4:0] a, logic wok);
    if (int'(a) >= nr(k) || (zr(k) && a == 5'd0)) return 32'h0;
    if (wok && wa_i[k] == a) return wd_i[k];
    return m_regs[k][a];
  endfunction

  task automatic model_edge(int k);
    logic wok;
    if (rst_i[k]) begin
      busy[k]  = nr(k);
      m_rdy[k] = 1'b0;
      m_vld[k] = 1'b0;
      m_rs1[k] = 32'h0;
      m_rs2[k] = 32'h0;
      known[k] = 1'b1;
    end else if (!m_rdy[k]) begin
      m_vld[k] = 1'b0;
      if (m_rs1[k] != 32'h0 || m_rs2[k] != 32'h0) known[k] = 1'b0;
      busy[k]--;
      if (busy[k] == 0) begin
        for (int i = 0; i < 32; i++) m_regs[k][i] = 32'h0;
        m_rdy[k] = 1'b1;
      end
    end else begin
      wok = we_i[k] && !clr_i[k] && (int'(wa_i[k]) < nr(k)) && !(zr(k) && wa_i[k] == 5'd0);
      m_vld[k] = re_i[k];
      if (re_i[k]) begin
        m_rs1[k] = rdval(k, a1_i[k], wok);
        m_rs2[k] = rdval(k, a2_i[k], wok);
        known[k] = 1'b1;
      end
      if (wok) m_regs[k][wa_i[k]] = wd_i[k];
      if (clr_i[k]) begin
        busy[k]  = nr(k);
        m_rdy[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s [%s] observed=%h expected=%h", name, tag, obs, exp);
    end
  endtask

  task automatic check_inst(int k, logic rdy, logic vld, logic [31:0] r1, logic [31:0] r2);
    chk($sformatf("ready%0d", k), {31'b0, rdy}, {31'b0, m_rdy[k]});
    chk($sformatf("rs_valid%0d", k), {31'b0, vld}, {31'b0, m_vld[k]});
    if (known[k]) begin
      chk($sformatf("rs1_%0d", k), r1, m_rs1[k]);
      chk($sformatf("rs2_%0d", k), r2, m_rs2[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_inst(0, rdy_a, vld_a, rs1_a, rs2_a);
    check_inst(1, rdy_b, vld_b, rs1_b, rs2_b);
  endtask

  task automatic idle(int k);
    rst_i[k] = 1'b0; clr_i[k] = 1'b0; re_i[k] = 1'b0; we_i[k] = 1'b0;
    a1_i[k] = 5'd0; a2_i[k] = 5'd0; wa_i[k] = 5'd0; wd_i[k] = 32'h0;
  endtask

  task automatic op(int k, logic re, logic [4:0] a1, logic [4:0] a2,
                    logic we, logic [4:0] wa, logic [31:0] wd, logic clr);
    re_i[k] = re; a1_i[k] = a1; a2_i[k] = a2;
    we_i[k] = we; wa_i[k] = wa; wd_i[k] = wd; clr_i[k] = clr;
    step();
    idle(k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      idle(k);
      rst_i[k] = 1'b1;
      busy[k] = nr(k); m_rdy[k] = 1'b0; m_vld[k] = 1'b0; known[k] = 1'b0;
      m_rs1[k] = 32'h0; m_rs2[k] = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[k][i] = 32'h0;
    end

    tag = "reset";
    step();
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;

    tag = "sweep";
    repeat (10) step();
    tag = "rst_mid_clear";
    rst_i[1] = 1'b1;
    step();
    rst_i[1] = 1'b0;
    tag = "sweep_finish";
    begin
      int n = 0;
      while (!(rdy_a && rdy_b) && n < 100) begin
        step();
        n++;
      end
    end
    chk("both_ready", {30'b0, rdy_a, rdy_b}, 32'h3);

    tag = "first_read";
    op(0, 1, 5'd5, 5'd5, 0, 5'd0, 32'h0, 0);

    tag = "basic_rw";
    op(0, 0, 5'd0, 5'd0, 1, 5'd3, 32'hDEADBEEF, 0);
    op(0, 1, 5'd3, 5'd0, 0, 5'd0, 32'h0, 0);
    chk("x3_read", rs1_a, 32'hDEADBEEF);
    op(0, 0, 5'd0, 5'd0, 1, 5'd0, 32'h1234, 0);
    op(0, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0);
    chk("x0_zero", rs1_a, 32'h0);

    tag = "bypass";
    op(0, 0, 5'd0, 5'd0, 1, 5'd10, 32'h11, 0);
    op(0, 1, 5'd10, 5'd10, 1, 5'd10, 32'hCAFEF00D, 0);
    chk("bypass_rs2", rs2_a, 32'hCAFEF00D);
    op(0, 1, 5'd10, 5'd10, 0, 5'd0, 32'h0, 0);

    tag = "hold";
    op(0, 0, 5'd0, 5'd0, 1, 5'd4, 32'hA5A5A5A5, 0);
    op(0, 1, 5'd4, 5'd4, 0, 5'd0, 32'h0, 0);
    repeat (3) step();
    chk("hold_rs1", rs1_a, 32'hA5A5A5A5);

    tag = "fill";
    for (int i = 1; i < 32; i++) op(0, 0, 5'd0, 5'd0, 1, 5'(i), $urandom | 32'h1, 0);
    tag = "clear_req";
    op(0, 1, 5'd7, 5'd7, 1, 5'd7, 32'h77, 1);
    tag = "writes_during_clear";
    for (int i = 0; i < 32; i++) begin
      we_i[0] = 1'b1; wa_i[0] = 5'($urandom_range(1, 31)); wd_i[0] = $urandom | 32'h1;
      re_i[0] = 1'b1; a1_i[0] = wa_i[0]; a2_i[0] = 5'd7;
      step();
    end
    idle(0);
    tag = "after_clear";
    for (int i = 0; i < 32; i += 2) op(0, 1, 5'(i), 5'(i + 1), 0, 5'd0, 32'h0, 0);
    op(0, 1, 5'd7, 5'd7, 0, 5'd0, 32'h0, 0);
    chk("x7_cleared", rs1_a, 32'h0);

    tag = "b_no_zero_reg";
    op(1, 0, 5'd0, 5'd0, 1, 5'd0, 32'h5, 0);
    op(1, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0);
    chk("b_x0", rs1_b, 32'h5);
    tag = "b_out_of_range";
    op(1, 0, 5'd0, 5'd0, 1, 5'd30, 32'h9, 0);
    op(1, 1, 5'd30, 5'd30, 0, 5'd0, 32'h0, 0);
    chk("b_x30", rs1_b, 32'h0);
    op(1, 1, 5'd23, 5'd24, 1, 5'd23, 32'h2323, 0);
    chk("b_x23_bypass", rs1_b, 32'h2323);

    tag = "random";
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        rst_i[k] = ($urandom_range(0, 399) == 0);
        clr_i[k] = ($urandom_range(0, 79) == 0);
        re_i[k]  = 1'($urandom);
        we_i[k]  = 1'($urandom);
        wa_i[k]  = 5'($urandom_range(0, 31));
        wd_i[k]  = $urandom;
        a1_i[k]  = ($urandom_range(0, 2) == 0) ? wa_i[k] : 5'($urandom_range(0, 31));
        a2_i[k]  = ($urandom_range(0, 2) == 0) ? wa_i[k] : 5'($urandom_range(0, 31));
      end
      step();
    end
    idle(0);
    idle(1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
